plugboard_table: RTL and testbench
==================================

# plugboard_table

Parametrised, runtime-programmable plugboard for the Enigma datapath. It sits between the keyboard decoder and the rotor/reflector stage, and again between that stage and the display. It holds up to PAIRS symmetric letter swaps over an N-symbol one-hot alphabet. Pairs can be added, removed or cleared while running, and every lookup is registered with one-cycle latency.

## Interface
- N, default 26: alphabet size; width of every one-hot letter bus.
- PAIRS, default 10: maximum number of stored swap pairs.
- IW, default $clog2(N): internal letter-index width. Derived; do not override.
- CW, default $clog2(PAIRS+1): width of pair_count. Derived.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous; empties the table.
- cfg_valid  in  1  configuration request.
- cfg_op  in  1  0 = add pair, 1 = remove pair containing cfg_a.
- cfg_a, cfg_b  in  N each  one-hot letters; cfg_b is ignored for remove.
- cfg_ready  out  1  high when a request can be accepted.
- cfg_done  out  1  one-cycle pulse reporting the result of an accepted request.
- cfg_err  out  2  result code, valid while cfg_done is high.
- in_valid  in  1  lookup request.
- in  in  N  one-hot letter to substitute.
- out_valid  out  1  lookup result valid.
- out  out  N  substituted one-hot letter.
- pair_count  out  CW  number of stored pairs.
- full  out  1  pair_count == PAIRS.

## Operation
- Storage: PAIRS slots, each holding {used, idx_a[IW], idx_b[IW]}. Swaps are symmetric, so a→b implies b→a.
- A request is accepted when cfg_valid && cfg_ready. cfg_ready = ~clear.
- Add checks, in priority order:
  - cfg_a or cfg_b not exactly one-hot, or cfg_a == cfg_b → err 1 (ENC).
  - Either letter already in a used slot → err 2 (CONFLICT).
  - Table full → err 3 (FULL).
  - Otherwise the pair goes into the lowest-index free slot → err 0 (OK).
- Remove checks:
  - cfg_a not one-hot → err 1.
  - No used slot contains cfg_a as either member → err 2.
  - Otherwise that slot is freed → err 0.
- Any rejected request leaves the table unchanged.
- clear frees all slots and drops any request presented in the same cycle: no cfg_done, no change.
- Lookup: if `in` is one-hot and matches a member of a used slot, out = its partner. If one-hot and unmatched, out = in. If not one-hot (zero or multi-hot), out = 0.

## Timing
- Reset values: every slot unused; pair_count = 0; full = 0; cfg_done = 0; cfg_err = 0; out_valid = 0; out = 0.
- Lookup latency is 1 cycle. out_valid(t+1) = in_valid(t). out holds its last value while out_valid is low.
- A back-to-back lookup issues every cycle; there is no stall.
- Config latency is 1 cycle. cfg_done and cfg_err register on the edge after acceptance, and the table update is visible to lookups issued from that same edge onward.
- A lookup and a config change in the same cycle: the lookup uses the table as it was before the change. The same rule applies to clear.
- pair_count and full update on the same edge as the table.
- Reset asserted mid-operation clears everything immediately. A pending cfg_done or out_valid is lost.

## Structure
- Package plugboard_pkg holds:
  - Error codes: ERR_OK = 0, ERR_ENC = 1, ERR_CONFLICT = 2, ERR_FULL = 3.
  - Op codes: OP_ADD = 0, OP_REMOVE = 1.
  - Defaults: N = 26, PAIRS = 10.
- Sub-module onehot_enc: N-bit one-hot in, IW-bit index plus `ok` out; `ok` is 0 for zero or multi-hot input. It is instantiated for cfg_a, cfg_b and in.
- Slot match and lowest-free-slot search are parametrised generate loops in the top module.

## Test plan
- Reset, then lookup in = A (bit 0) → one cycle later out_valid = 1, out = A; pair_count = 0.
- Add (A, Q); lookup A then Q back-to-back → out = Q, then A; cfg_err = 0; pair_count = 1.
- Add (A, Z) after (A, Q) → cfg_err = 2; table unchanged. Add with cfg_a = 26'h3 → cfg_err = 1.
- Fill 10 pairs; an 11th valid add → cfg_err = 3; full = 1. Remove Q → cfg_err = 0; pair_count = 9; lookup Q → Q.
- Lookup of A issued in the same cycle as add (A, B) → out = A. The next-cycle lookup of A → B. clear asserted together with cfg_valid → no cfg_done, pair_count = 0.
- Assert reset mid-stream with a table holding 5 pairs → all outputs return to zero immediately; lookups after release pass letters through unchanged.

Source files
------------

// File: rtl/plugboard_pkg.sv
// rtl/plugboard_pkg.sv - shared codes and defaults for the plugboard table
package plugboard_pkg;

  localparam int N_DEFAULT     = 26;
  localparam int PAIRS_DEFAULT = 10;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_ENC      = 2'd1,
    ERR_CONFLICT = 2'd2,
    ERR_FULL     = 2'd3
  } err_t;

  typedef enum logic {
    OP_ADD    = 1'b0,
    OP_REMOVE = 1'b1
  } op_t;

endpackage

// File: rtl/plugboard_table_if.sv
// rtl/plugboard_table_if.sv - configuration and lookup bundle for plugboard_table
interface plugboard_table_if #(
  parameter int N = 26
);
  logic         cfg_valid;
  logic         cfg_op;
  logic [N-1:0] cfg_a;
  logic [N-1:0] cfg_b;
  logic         cfg_ready;
  logic         cfg_done;
  logic [1:0]   cfg_err;
  logic         in_valid;
  logic [N-1:0] in;
  logic         out_valid;
  logic [N-1:0] out;

  modport master (
    output cfg_valid, cfg_op, cfg_a, cfg_b, in_valid, in,
    input  cfg_ready, cfg_done, cfg_err, out_valid, out
  );

  modport slave (
    input  cfg_valid, cfg_op, cfg_a, cfg_b, in_valid, in,
    output cfg_ready, cfg_done, cfg_err, out_valid, out
  );
endinterface

// File: rtl/plugboard_table_onehot_enc.sv
// rtl/plugboard_table_onehot_enc.sv - one-hot to index encoder with validity flag
module onehot_enc #(
  parameter int N  = 26,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  code,
  output logic [IW-1:0] idx,
  output logic          ok
);

  // idx is only meaningful when ok is set; multi-hot inputs OR their indices
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (code[i]) idx = idx | IW'(i);
    end
  end

  assign ok = (code != '0) && ((code & (code - N'(1))) == '0);

endmodule

// File: rtl/plugboard_table.sv
// rtl/plugboard_table.sv - runtime-programmable symmetric letter-swap table
module plugboard_table
  import plugboard_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int PAIRS = PAIRS_DEFAULT,
  parameter int IW    = $clog2(N),
  parameter int CW    = $clog2(PAIRS + 1)
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic            clear,
  plugboard_table_if.slave bus,
  output logic [CW-1:0]   pair_count,
  output logic            full
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [PAIRS-1:0] used;
  logic [IW-1:0]    slot_a [PAIRS];
  logic [IW-1:0]    slot_b [PAIRS];

  logic [IW-1:0] a_idx, b_idx, in_idx;
  logic          a_ok, b_ok, in_ok;

  onehot_enc #(.N(N), .IW(IW)) u_enc_a  (.code(bus.cfg_a), .idx(a_idx),  .ok(a_ok));
  onehot_enc #(.N(N), .IW(IW)) u_enc_b  (.code(bus.cfg_b), .idx(b_idx),  .ok(b_ok));
  onehot_enc #(.N(N), .IW(IW)) u_enc_in (.code(bus.in),    .idx(in_idx), .ok(in_ok));

  logic [PAIRS-1:0] hit_a, hit_b, hit_in, first_free;
  logic [PAIRS:0]   free_seen;
  logic [N-1:0]     partner [PAIRS];

  assign free_seen[0] = 1'b0;

  // free_seen[p] marks that some slot below p is free, so first_free is one-hot
  for (genvar p = 0; p < PAIRS; p++) begin : g_slot
    assign hit_a[p]         = used[p] && (slot_a[p] == a_idx  || slot_b[p] == a_idx);
    assign hit_b[p]         = used[p] && (slot_a[p] == b_idx  || slot_b[p] == b_idx);
    assign hit_in[p]        = used[p] && (slot_a[p] == in_idx || slot_b[p] == in_idx);
    assign first_free[p]    = ~used[p] & ~free_seen[p];
    assign free_seen[p + 1] = free_seen[p] | ~used[p];
    assign partner[p]       = hit_in[p]
                            ? (ONE << ((slot_a[p] == in_idx) ? slot_b[p] : slot_a[p]))
                            : '0;
  end

  err_t err;
  logic accept, commit;

  always_comb begin
    err = ERR_OK;
    if (bus.cfg_op == OP_REMOVE) begin
      if (!a_ok)                err = ERR_ENC;
      else if (hit_a == '0)     err = ERR_CONFLICT;
    end else begin
      if (!a_ok || !b_ok || a_idx == b_idx) err = ERR_ENC;
      else if ((hit_a | hit_b) != '0)       err = ERR_CONFLICT;
      else if (!free_seen[PAIRS])           err = ERR_FULL;
    end
  end

  assign bus.cfg_ready = ~clear;
  assign accept        = bus.cfg_valid && bus.cfg_ready;
  assign commit        = accept && (err == ERR_OK);
  assign full          = (pair_count == CW'(PAIRS));

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      used       <= '0;
      pair_count <= '0;
      for (int p = 0; p < PAIRS; p++) begin
        slot_a[p] <= '0;
        slot_b[p] <= '0;
      end
    end else if (clear) begin
      used       <= '0;
      pair_count <= '0;
    end else if (commit) begin
      if (bus.cfg_op == OP_ADD) begin
        for (int p = 0; p < PAIRS; p++) begin
          if (first_free[p]) begin
            used[p]   <= 1'b1;
            slot_a[p] <= a_idx;
            slot_b[p] <= b_idx;
          end
        end
        pair_count <= pair_count + CW'(1);
      end else begin
        used       <= used & ~hit_a;
        pair_count <= pair_count - CW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      bus.cfg_done <= 1'b0;
      bus.cfg_err  <= ERR_OK;
    end else begin
      bus.cfg_done <= accept;
      if (accept) bus.cfg_err <= err;
    end
  end

  logic [N-1:0] mapped, lookup;

  always_comb begin
    mapped = '0;
    for (int p = 0; p < PAIRS; p++) mapped = mapped | partner[p];
    if (!in_ok)             lookup = '0;
    else if (hit_in != '0)  lookup = mapped;
    else                    lookup = bus.in;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.out <= lookup;
    end
  end

endmodule

// File: tb/tb_plugboard_table.sv
// tb/tb_plugboard_table.sv - randomized self-checking bench for plugboard_table
module tb_plugboard_table;
  import plugboard_pkg::*;

  localparam int N     = 26;
  localparam int PAIRS = 10;
  localparam int CW    = $clog2(PAIRS + 1);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] pair_count;
  logic          full;

  plugboard_table_if #(.N(N)) bus ();

  plugboard_table #(.N(N), .PAIRS(PAIRS)) dut (
    .CLOCK_50  (clk),
    .reset     (rst_n),
    .clear     (clear),
    .bus       (bus),
    .pair_count(pair_count),
    .full      (full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference: mate[i] is the partner letter of i, or -1
  int mate [N];
  int cnt;

  logic         exp_done;
  logic [1:0]   exp_err;
  logic         exp_ov;
  logic [N-1:0] exp_out;

  function automatic logic [N-1:0] letter(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) mate[i] = -1;
    cnt = 0;
  endfunction

  function automatic logic [N-1:0] model_lookup(input logic [N-1:0] v);
    int i;
    i = idx_of(v);
    if (i < 0) return '0;
    if (mate[i] >= 0) return letter(mate[i]);
    return v;
  endfunction

  function automatic logic [1:0] model_cfg(input logic op, input logic [N-1:0] ca, input logic [N-1:0] cb);
    int a, b;
    a = idx_of(ca);
    b = idx_of(cb);
    if (op == OP_REMOVE) begin
      if (a < 0) return 2'd1;
      if (mate[a] < 0) return 2'd2;
      mate[mate[a]] = -1;
      mate[a] = -1;
      cnt--;
      return 2'd0;
    end
    if (a < 0 || b < 0 || a == b) return 2'd1;
    if (mate[a] >= 0 || mate[b] >= 0) return 2'd2;
    if (cnt == PAIRS) return 2'd3;
    mate[a] = b;
    mate[b] = a;
    cnt++;
    return 2'd0;
  endfunction

  // one clock: predict from the current drive, advance, sample #1 after the edge
  task automatic step();
    logic         n_ov, n_done;
    logic [N-1:0] n_out;
    logic [1:0]   n_err;
    n_ov   = bus.in_valid;
    n_out  = bus.in_valid ? model_lookup(bus.in) : exp_out;
    n_done = bus.cfg_valid && !clear;
    n_err  = n_done ? model_cfg(bus.cfg_op, bus.cfg_a, bus.cfg_b) : exp_err;
    if (clear) model_reset();
    @(posedge clk);
    #1;
    exp_ov   = n_ov;
    exp_out  = n_out;
    exp_done = n_done;
    exp_err  = n_err;
  endtask

  task automatic idle();
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b0;
    clear         = 1'b0;
  endtask

  task automatic cfg(input logic op, input logic [N-1:0] a, input logic [N-1:0] b);
    bus.cfg_valid = 1'b1;
    bus.cfg_op    = op;
    bus.cfg_a     = a;
    bus.cfg_b     = b;
  endtask

  task automatic look(input logic [N-1:0] v);
    bus.in_valid = 1'b1;
    bus.in       = v;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (pair_count !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", pair_count); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (bus.cfg_done !== 1'b0 || bus.cfg_err !== 2'd0) begin n_bad++; $display("FAIL reset_cfg got %b/%0d want 0/0", bus.cfg_done, bus.cfg_err); end
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out !== '0) begin n_bad++; $display("FAIL reset_out got %b/%h want 0/0", bus.out_valid, bus.out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL ready got %b want 1", bus.cfg_ready); end
    look(letter(0));
    step();
    idle();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out !== letter(0)) begin n_bad++; $display("FAIL passthru_A got %b/%h want 1/%h", bus.out_valid, bus.out, letter(0)); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out !== letter(0)) begin n_bad++; $display("FAIL out_hold got %b/%h want 0/%h", bus.out_valid, bus.out, letter(0)); end
  endtask

  task automatic test_add_lookup();
    cfg(OP_ADD, letter(0), letter(16));
    step();
    idle();
    n_cmp++; if (bus.cfg_done !== 1'b1 || bus.cfg_err !== 2'd0) begin n_bad++; $display("FAIL add_AQ got %b/%0d want 1/0", bus.cfg_done, bus.cfg_err); end
    n_cmp++; if (pair_count !== CW'(1)) begin n_bad++; $display("FAIL add_AQ_count got %0d want 1", pair_count); end
    look(letter(0));
    step();
    n_cmp++; if (bus.cfg_done !== 1'b0) begin n_bad++; $display("FAIL done_pulse got %b want 0", bus.cfg_done); end
    n_cmp++; if (bus.out !== letter(16)) begin n_bad++; $display("FAIL look_A got %h want %h", bus.out, letter(16)); end
    look(letter(16));
    step();
    idle();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out !== letter(0)) begin n_bad++; $display("FAIL look_Q got %b/%h want 1/%h", bus.out_valid, bus.out, letter(0)); end
    look(26'h3);
    step();
    idle();
    n_cmp++; if (bus.out !== '0) begin n_bad++; $display("FAIL look_multi got %h want 0", bus.out); end
  endtask

  task automatic test_errors();
    cfg(OP_ADD, letter(0), letter(25));
    step();
    n_cmp++; if (bus.cfg_err !== 2'd2) begin n_bad++; $display("FAIL add_AZ got %0d want 2", bus.cfg_err); end
    cfg(OP_ADD, 26'h3, letter(25));
    step();
    n_cmp++; if (bus.cfg_err !== 2'd1) begin n_bad++; $display("FAIL add_multi got %0d want 1", bus.cfg_err); end
    cfg(OP_ADD, letter(5), letter(5));
    step();
    n_cmp++; if (bus.cfg_err !== 2'd1) begin n_bad++; $display("FAIL add_same got %0d want 1", bus.cfg_err); end
    cfg(OP_REMOVE, '0, letter(0));
    step();
    n_cmp++; if (bus.cfg_err !== 2'd1) begin n_bad++; $display("FAIL rem_zero got %0d want 1", bus.cfg_err); end
    cfg(OP_REMOVE, letter(7), letter(0));
    step();
    idle();
    n_cmp++; if (bus.cfg_done !== 1'b1 || bus.cfg_err !== 2'd2) begin n_bad++; $display("FAIL rem_absent got %b/%0d want 1/2", bus.cfg_done, bus.cfg_err); end
    n_cmp++; if (pair_count !== CW'(1)) begin n_bad++; $display("FAIL err_count got %0d want 1", pair_count); end
    look(letter(25));
    step();
    idle();
    n_cmp++; if (bus.out !== letter(25)) begin n_bad++; $display("FAIL look_Z got %h want %h", bus.out, letter(25)); end
  endtask

  task automatic test_fill();
    int free_l [$];
    for (int i = 1; i < N; i++) if (i != 16) free_l.push_back(i);
    for (int k = 0; k < PAIRS - 1; k++) begin
      cfg(OP_ADD, letter(free_l[2*k]), letter(free_l[2*k+1]));
      step();
    end
    n_cmp++; if (bus.cfg_err !== 2'd0 || pair_count !== CW'(PAIRS) || full !== 1'b1) begin n_bad++; $display("FAIL fill got err %0d count %0d full %b want 0/%0d/1", bus.cfg_err, pair_count, full, PAIRS); end
    cfg(OP_ADD, letter(free_l[18]), letter(free_l[19]));
    step();
    n_cmp++; if (bus.cfg_err !== 2'd3 || full !== 1'b1) begin n_bad++; $display("FAIL add_full got %0d/%b want 3/1", bus.cfg_err, full); end
    cfg(OP_REMOVE, letter(16), letter(3));
    step();
    idle();
    n_cmp++; if (bus.cfg_err !== 2'd0 || pair_count !== CW'(PAIRS - 1) || full !== 1'b0) begin n_bad++; $display("FAIL rem_Q got %0d/%0d/%b want 0/9/0", bus.cfg_err, pair_count, full); end
    look(letter(16));
    step();
    n_cmp++; if (bus.out !== letter(16)) begin n_bad++; $display("FAIL look_Q_freed got %h want %h", bus.out, letter(16)); end
    look(letter(0));
    step();
    idle();
    n_cmp++; if (bus.out !== letter(0)) begin n_bad++; $display("FAIL look_A_freed got %h want %h", bus.out, letter(0)); end
  endtask

  task automatic test_same_cycle();
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++; if (pair_count !== '0 || full !== 1'b0) begin n_bad++; $display("FAIL clear got %0d/%b want 0/0", pair_count, full); end
    cfg(OP_ADD, letter(0), letter(1));
    look(letter(0));
    step();
    bus.cfg_valid = 1'b0;
    n_cmp++; if (bus.out !== letter(0) || bus.cfg_err !== 2'd0) begin n_bad++; $display("FAIL same_cycle got %h/%0d want %h/0", bus.out, bus.cfg_err, letter(0)); end
    step();
    n_cmp++; if (bus.out !== letter(1)) begin n_bad++; $display("FAIL next_cycle got %h want %h", bus.out, letter(1)); end
    clear = 1'b1;
    cfg(OP_ADD, letter(2), letter(3));
    step();
    n_cmp++; if (bus.cfg_done !== 1'b0 || pair_count !== '0) begin n_bad++; $display("FAIL clear_drop got %b/%0d want 0/0", bus.cfg_done, pair_count); end
    n_cmp++; if (bus.out !== letter(1)) begin n_bad++; $display("FAIL clear_old_table got %h want %h", bus.out, letter(1)); end
    idle();
    look(letter(2));
    step();
    idle();
    n_cmp++; if (bus.out !== letter(2)) begin n_bad++; $display("FAIL clear_dropped_add got %h want %h", bus.out, letter(2)); end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    for (int c = 0; c < 600; c++) begin
      bus.cfg_valid = ($urandom_range(0, 1) == 1);
      bus.cfg_op    = ($urandom_range(0, 3) == 0);
      bus.cfg_a     = letter($urandom_range(0, N - 1));
      bus.cfg_b     = letter($urandom_range(0, N - 1));
      if ($urandom_range(0, 15) == 0) bus.cfg_a = bus.cfg_a | letter($urandom_range(0, N - 1));
      if ($urandom_range(0, 15) == 0) bus.cfg_b = '0;
      v = letter($urandom_range(0, N - 1));
      if ($urandom_range(0, 11) == 0) v = '0;
      if ($urandom_range(0, 11) == 0) v = v | letter($urandom_range(0, N - 1));
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in       = v;
      clear        = ($urandom_range(0, 79) == 0);
      step();
      n_cmp++; if (bus.out_valid !== exp_ov || bus.out !== exp_out) begin n_bad++; $display("FAIL rnd_out c%0d got %b/%h want %b/%h", c, bus.out_valid, bus.out, exp_ov, exp_out); end
      n_cmp++; if (bus.cfg_done !== exp_done || (exp_done && bus.cfg_err !== exp_err)) begin n_bad++; $display("FAIL rnd_cfg c%0d got %b/%0d want %b/%0d", c, bus.cfg_done, bus.cfg_err, exp_done, exp_err); end
      n_cmp++; if (pair_count !== CW'(cnt) || full !== (cnt == PAIRS)) begin n_bad++; $display("FAIL rnd_count c%0d got %0d/%b want %0d/%b", c, pair_count, full, cnt, cnt == PAIRS); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cfg(OP_ADD, letter(2*k), letter(2*k + 1));
      step();
    end
    n_cmp++; if (pair_count !== CW'(5)) begin n_bad++; $display("FAIL five_pairs got %0d want 5", pair_count); end
    cfg(OP_ADD, letter(20), letter(21));
    look(letter(0));
    @(posedge clk);
    #2;
    idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    exp_out = '0;
    exp_err = '0;
    n_cmp++; if (pair_count !== '0 || full !== 1'b0) begin n_bad++; $display("FAIL mid_rst_count got %0d/%b want 0/0", pair_count, full); end
    n_cmp++; if (bus.cfg_done !== 1'b0 || bus.cfg_err !== 2'd0 || bus.out_valid !== 1'b0 || bus.out !== '0) begin n_bad++; $display("FAIL mid_rst_out got %b/%0d/%b/%h want all 0", bus.cfg_done, bus.cfg_err, bus.out_valid, bus.out); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      look(letter(k));
      step();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out !== letter(k)) begin n_bad++; $display("FAIL post_rst_look k%0d got %b/%h want 1/%h", k, bus.out_valid, bus.out, letter(k)); end
    end
    idle();
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_op    = 1'b0;
    bus.cfg_a     = '0;
    bus.cfg_b     = '0;
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    exp_done      = 1'b0;
    exp_err       = '0;
    exp_ov        = 1'b0;
    exp_out       = '0;
    model_reset();
    test_reset();
    test_add_lookup();
    test_errors();
    test_fill();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
